// File: rtl/serdes_pkg.sv
// Shared definitions for the serial lane: word width, slot positions, default
// control words and the scheduler state encoding.
package serdes_pkg;

    localparam int WORD_W = 10;

    localparam logic [3:0] SLOT_LAST   = 4'd9;
    localparam logic [3:0] SLOT_DECIDE = 4'd8;

    localparam logic [WORD_W-1:0] DEF_IDLE_WORD  = 10'h0FA;
    localparam logic [WORD_W-1:0] DEF_TRAIN_WORD = 10'h2AA;

    typedef enum logic [1:0] {
        TRAIN = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } sched_state_t;

    // Frame slot sequence 0..9; must match the serializer's bit counter.
    function automatic logic [3:0] slot_next(input logic [3:0] slot);
        return (slot == SLOT_LAST) ? 4'd0 : slot + 4'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping modulo NUM_REQ). Nothing is granted while en is low.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        index    = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = int'(ptr) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                cand_idx = IDX_W'(cand);
                if (!any && req[cand_idx]) begin
                    any           = 1'b1;
                    gnt[cand_idx] = 1'b1;
                    index         = cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one 10-bit serial lane between NUM_REQ requesters: training burst after
// reset, then one round-robin granted word (or an idle word) per 10-cycle frame.
module serial_tx_scheduler
    import serdes_pkg::*;
#(
    parameter int                NUM_REQ     = 4,
    parameter int                TRAIN_WORDS = 16,
    parameter logic [WORD_W-1:0] IDLE_WORD   = DEF_IDLE_WORD,
    parameter logic [WORD_W-1:0] TRAIN_WORD  = DEF_TRAIN_WORD,
    localparam int               IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [WORD_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [WORD_W-1:0]         para_word,
    output logic                      word_load,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      data_frame,
    output logic                      training_done,
    output logic [15:0]               word_cnt,
    output sched_state_t              dbg_state
);

    // Handshake: a word moves when req_valid[i] & req_ready[i] in slot 8.
    // req_ready is combinational from req_valid, so req_valid must never
    // depend on req_ready; ready is low in all other slots and in TRAIN/HOLD.

    localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_WORDS - 1);

    logic [3:0]          slot;
    sched_state_t        state, state_nxt;
    logic [7:0]          train_cnt;
    logic [IDX_W-1:0]    rr_ptr;
    logic                decide, last, arb_en;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [WORD_W-1:0]   sel_data;

    assign decide = (slot == SLOT_DECIDE);
    assign last   = (slot == SLOT_LAST);
    assign arb_en = decide && (state == RUN) && enable;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .en    (arb_en),
        .gnt   (arb_gnt),
        .index (arb_idx),
        .any   (arb_any)
    );

    assign req_ready     = arb_gnt;
    assign word_load     = last;
    assign training_done = (state != TRAIN);
    assign dbg_state     = state;

    // One-hot grant selects the requester's word slice.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = sel_data | req_data[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TRAIN: if (last && (train_cnt == TRAIN_LAST)) state_nxt = RUN;
            RUN:   if (decide && !enable)                 state_nxt = HOLD;
            HOLD:  if (decide && enable)                  state_nxt = RUN;
            default:                                      state_nxt = TRAIN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= 4'd0;
            state     <= TRAIN;
            train_cnt <= 8'd0;
        end else begin
            slot  <= slot_next(slot);
            state <= state_nxt;
            if (last && (state == TRAIN)) begin
                train_cnt <= train_cnt + 8'd1;
            end
        end
    end

    // The word for the next serializer load is fixed at the end of slot 8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            para_word  <= TRAIN_WORD;
            grant_id   <= '0;
            data_frame <= 1'b0;
            rr_ptr     <= '0;
            word_cnt   <= 16'd0;
        end else if (decide) begin
            if (state == TRAIN) begin
                para_word  <= TRAIN_WORD;
                data_frame <= 1'b0;
            end else if (arb_any) begin
                para_word  <= sel_data;
                grant_id   <= arb_idx;
                data_frame <= 1'b1;
                rr_ptr     <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                if (word_cnt != 16'hFFFF) begin
                    word_cnt <= word_cnt + 16'd1;
                end
            end else begin
                para_word  <= IDLE_WORD;
                data_frame <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench for serial_tx_scheduler with NUM_REQ=4, TRAIN_WORDS=4.
module tb_serial_tx_scheduler;
    import serdes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [3:0]   req_valid = 4'h0;
    logic [39:0]  req_data = 40'h0;
    logic [3:0]   req_ready;
    logic [9:0]   para_word;
    logic         word_load;
    logic [1:0]   grant_id;
    logic         data_frame;
    logic         training_done;
    logic [15:0]  word_cnt;
    sched_state_t dbg_state;

    int tests = 0;
    int fails = 0;
    int tb_cyc;

    serial_tx_scheduler #(.NUM_REQ(4), .TRAIN_WORDS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .para_word     (para_word),
        .word_load     (word_load),
        .grant_id      (grant_id),
        .data_frame    (data_frame),
        .training_done (training_done),
        .word_cnt      (word_cnt),
        .dbg_state     (dbg_state)
    );

    // clock / reset-relative cycle number (cycle 0 = first cycle after release)
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    task automatic goto_slot(input int s);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((tb_cyc % 10) != s) && (n < 25));
        if ((tb_cyc % 10) != s) begin
            tests++; fails++;
            $display("FAIL goto_slot timeout: got slot %0d, expected %0d", tb_cyc % 10, s);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (para_word !== 10'h2AA) begin fails++; $display("FAIL reset para_word: got %h, expected 2aa", para_word); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset grant_id: got %0d, expected 0", grant_id); end
        tests++; if (data_frame !== 1'b0) begin fails++; $display("FAIL reset data_frame: got %b, expected 0", data_frame); end
        tests++; if (training_done !== 1'b0) begin fails++; $display("FAIL reset training_done: got %b, expected 0", training_done); end
        tests++; if (word_cnt !== 16'd0) begin fails++; $display("FAIL reset word_cnt: got %h, expected 0", word_cnt); end
        tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL reset req_ready: got %b, expected 0000", req_ready); end
        tests++; if (word_load !== 1'b0) begin fails++; $display("FAIL reset word_load: got %b, expected 0", word_load); end
        tests++; if (dbg_state !== TRAIN) begin fails++; $display("FAIL reset state: got %0d, expected 0", dbg_state); end
    endtask

    // Release reset, no requests: 4 training loads at 9/19/29/39, then idle.
    task automatic test_training();
        logic [9:0] exp_w;
        enable = 1'b1;
        req_valid = 4'h0;
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tests++; if (word_load !== ((c % 10) == 9)) begin fails++; $display("FAIL train word_load c=%0d: got %b, expected %b", c, word_load, (c % 10) == 9); end
            if ((c % 10) == 9) begin
                exp_w = (c < 40) ? 10'h2AA : 10'h0FA;
                tests++; if (para_word !== exp_w) begin fails++; $display("FAIL train para_word c=%0d: got %h, expected %h", c, para_word, exp_w); end
            end
            tests++; if (training_done !== (c >= 40)) begin fails++; $display("FAIL train training_done c=%0d: got %b, expected %b", c, training_done, c >= 40); end
            tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL train req_ready c=%0d: got %b, expected 0000", c, req_ready); end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        int g;
        req_data  = {10'h004, 10'h003, 10'h002, 10'h001};
        req_valid = 4'hF;
        for (int f = 0; f < 8; f++) begin
            g = f % 4;
            goto_slot(7);
            tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL rr slot7 ready f=%0d: got %b, expected 0000", f, req_ready); end
            goto_slot(8);
            tests++; if (req_ready !== (4'b0001 << g)) begin fails++; $display("FAIL rr ready f=%0d: got %b, expected %b", f, req_ready, 4'b0001 << g); end
            goto_slot(9);
            tests++; if (para_word !== 10'(g + 1)) begin fails++; $display("FAIL rr para_word f=%0d: got %h, expected %h", f, para_word, 10'(g + 1)); end
            tests++; if (grant_id !== 2'(g)) begin fails++; $display("FAIL rr grant_id f=%0d: got %0d, expected %0d", f, grant_id, g); end
            tests++; if (data_frame !== 1'b1) begin fails++; $display("FAIL rr data_frame f=%0d: got %b, expected 1", f, data_frame); end
            tests++; if (word_cnt !== 16'(f + 1)) begin fails++; $display("FAIL rr word_cnt f=%0d: got %0d, expected %0d", f, word_cnt, f + 1); end
        end
    endtask

    // Requester 2 alone, then requester 1 joins while rr_ptr=3.
    task automatic test_rotation();
        int exp_g [5] = '{2, 2, 1, 2, 1};
        req_valid = 4'b0100;
        for (int f = 0; f < 5; f++) begin
            if (f == 2) req_valid = 4'b0110;
            goto_slot(8);
            tests++; if (req_ready !== (4'b0001 << exp_g[f])) begin fails++; $display("FAIL rot ready f=%0d: got %b, expected %b", f, req_ready, 4'b0001 << exp_g[f]); end
            goto_slot(9);
            tests++; if (grant_id !== 2'(exp_g[f])) begin fails++; $display("FAIL rot grant_id f=%0d: got %0d, expected %0d", f, grant_id, exp_g[f]); end
            tests++; if (para_word !== 10'(exp_g[f] + 1)) begin fails++; $display("FAIL rot para_word f=%0d: got %h, expected %h", f, para_word, 10'(exp_g[f] + 1)); end
            tests++; if (word_cnt !== 16'(9 + f)) begin fails++; $display("FAIL rot word_cnt f=%0d: got %0d, expected %0d", f, word_cnt, 9 + f); end
        end
    endtask

    task automatic test_enable();
        req_valid = 4'hF;
        goto_slot(8);
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL en pre ready: got %b, expected 0100", req_ready); end
        goto_slot(9);
        enable = 1'b0;
        #1;
        tests++; if (word_load !== 1'b1) begin fails++; $display("FAIL en captured load: got %b, expected 1", word_load); end
        tests++; if (para_word !== 10'h003) begin fails++; $display("FAIL en captured word: got %h, expected 003", para_word); end
        goto_slot(8);
        tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL en off ready: got %b, expected 0000", req_ready); end
        goto_slot(9);
        tests++; if (para_word !== 10'h0FA) begin fails++; $display("FAIL en off para_word: got %h, expected 0fa", para_word); end
        tests++; if (data_frame !== 1'b0) begin fails++; $display("FAIL en off data_frame: got %b, expected 0", data_frame); end
        tests++; if (dbg_state !== HOLD) begin fails++; $display("FAIL en off state: got %0d, expected 2", dbg_state); end
        tests++; if (word_cnt !== 16'd14) begin fails++; $display("FAIL en off word_cnt: got %0d, expected 14", word_cnt); end
        enable = 1'b1;
        goto_slot(8);
        tests++; if (req_ready !== 4'h0) begin fails++; $display("FAIL en hold ready: got %b, expected 0000", req_ready); end
        goto_slot(9);
        tests++; if (para_word !== 10'h0FA) begin fails++; $display("FAIL en hold para_word: got %h, expected 0fa", para_word); end
        tests++; if (dbg_state !== RUN) begin fails++; $display("FAIL en resume state: got %0d, expected 1", dbg_state); end
        goto_slot(8);
        tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL en resume ready: got %b, expected 1000", req_ready); end
        goto_slot(9);
        tests++; if (para_word !== 10'h004) begin fails++; $display("FAIL en resume para_word: got %h, expected 004", para_word); end
        tests++; if (grant_id !== 2'd3) begin fails++; $display("FAIL en resume grant_id: got %0d, expected 3", grant_id); end
        tests++; if (word_cnt !== 16'd15) begin fails++; $display("FAIL en resume word_cnt: got %0d, expected 15", word_cnt); end
    endtask

    task automatic test_saturation();
        goto_slot(0);
        force dut.word_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.word_cnt;
        tests++; if (word_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat preload: got %h, expected fffe", word_cnt); end
        for (int f = 0; f < 3; f++) begin
            goto_slot(9);
            tests++; if (word_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat word_cnt f=%0d: got %h, expected ffff", f, word_cnt); end
            tests++; if (para_word !== 10'(f + 1)) begin fails++; $display("FAIL sat para_word f=%0d: got %h, expected %h", f, para_word, 10'(f + 1)); end
        end
    endtask

    task automatic test_reset_mid();
        goto_slot(5);
        tests++; if (data_frame !== 1'b1) begin fails++; $display("FAIL rmid pre data_frame: got %b, expected 1", data_frame); end
        rst_n = 1'b0;
        #1;
        tests++; if (para_word !== 10'h2AA) begin fails++; $display("FAIL rmid para_word: got %h, expected 2aa", para_word); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL rmid grant_id: got %0d, expected 0", grant_id); end
        tests++; if (data_frame !== 1'b0) begin fails++; $display("FAIL rmid data_frame: got %b, expected 0", data_frame); end
        tests++; if (training_done !== 1'b0) begin fails++; $display("FAIL rmid training_done: got %b, expected 0", training_done); end
        tests++; if (word_cnt !== 16'd0) begin fails++; $display("FAIL rmid word_cnt: got %h, expected 0", word_cnt); end
        tests++; if (dbg_state !== TRAIN) begin fails++; $display("FAIL rmid state: got %0d, expected 0", dbg_state); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tests++; if (word_load !== ((c % 10) == 9)) begin fails++; $display("FAIL rmid word_load c=%0d: got %b, expected %b", c, word_load, (c % 10) == 9); end
            if ((c % 10) == 9 && c < 40) begin
                tests++; if (para_word !== 10'h2AA) begin fails++; $display("FAIL rmid train word c=%0d: got %h, expected 2aa", c, para_word); end
            end
            if (c == 48) begin
                tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rmid first ready: got %b, expected 0001", req_ready); end
            end
            if (c == 49) begin
                tests++; if (para_word !== 10'h001) begin fails++; $display("FAIL rmid first word: got %h, expected 001", para_word); end
                tests++; if (word_cnt !== 16'd1) begin fails++; $display("FAIL rmid first word_cnt: got %0d, expected 1", word_cnt); end
            end
            tests++; if (training_done !== (c >= 40)) begin fails++; $display("FAIL rmid training_done c=%0d: got %b, expected %b", c, training_done, c >= 40); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_training();
        test_round_robin();
        test_rotation();
        test_enable();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
